// File: rtl/cu_pkg.sv
// Shared definitions for the Mini SRC hardwired control unit: opcodes,
// controller states, instruction classes and the control-word layout.
package cu_pkg;

    localparam int NUM_STEPS = 8;
    localparam int STATE_W   = $clog2(NUM_STEPS + 3);
    localparam int OP_W      = 5;

    // Mini SRC instruction opcodes (IR[31:27])
    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b01000;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01001;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b01010;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01011;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
    localparam logic [OP_W-1:0] OP_JR   = 5'b10100;
    localparam logic [OP_W-1:0] OP_JAL  = 5'b10101;
    localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
    localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
    localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
    localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    // ALU operation codes driven on the opcode output
    localparam logic [OP_W-1:0] ALU_NONE = 5'b00000;
    localparam logic [OP_W-1:0] ALU_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] ALU_AND  = 5'b00101;
    localparam logic [OP_W-1:0] ALU_OR   = 5'b00110;

    typedef enum logic [STATE_W-1:0] {
        RESET_S = 4'd0,
        T0      = 4'd1,
        T1      = 4'd2,
        T2      = 4'd3,
        T3      = 4'd4,
        T4      = 4'd5,
        T5      = 4'd6,
        T6      = 4'd7,
        T7      = 4'd8,
        PAUSE   = 4'd9,
        HALT    = 4'd10
    } state_t;

    typedef enum logic [3:0] {
        CLS_LD   = 4'd0,
        CLS_LDI  = 4'd1,
        CLS_ST   = 4'd2,
        CLS_ALU  = 4'd3,
        CLS_IMM  = 4'd4,
        CLS_BR   = 4'd5,
        CLS_NOP  = 4'd6,
        CLS_HALT = 4'd7,
        CLS_ILL  = 4'd8
    } instr_class_t;

    typedef struct packed {
        logic            run;
        logic            illegal;
        logic [OP_W-1:0] opcode;
        logic            pc_out;
        logic            zhigh_out;
        logic            zlow_out;
        logic            mdr_out;
        logic            hi_out;
        logic            lo_out;
        logic            c_out;
        logic            in_port_out;
        logic            mdr_enable;
        logic            mar_enable;
        logic            z_enable;
        logic            y_enable;
        logic            pc_enable;
        logic            ir_enable;
        logic            read;
        logic            inc_pc;
        logic            ram_write_enable;
        logic            out_port_enable;
        logic            in_port_in;
        logic            con_in;
        logic            gra;
        logic            grb;
        logic            grc;
        logic            r_in;
        logic            r_out;
        logic            ba_out;
    } ctrl_t;

    // Groups an opcode into the execute sequence it follows.
    function automatic instr_class_t decode_class(input logic [OP_W-1:0] op);
        instr_class_t cls;
        case (op)
            OP_LD:   cls = CLS_LD;
            OP_LDI:  cls = CLS_LDI;
            OP_ST:   cls = CLS_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
                     cls = CLS_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:
                     cls = CLS_IMM;
            OP_BR:   cls = CLS_BR;
            OP_NOP:  cls = CLS_NOP;
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/control_unit_alu_opcode_map.sv
// Maps an instruction opcode to the ALU operation used by address
// arithmetic (ld/ldi/st/br) and the immediate ALU instructions.
module alu_opcode_map
    import cu_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output logic [OP_W-1:0] alu_op
);

    // Address calculations add; immediates use their register-form ALU op.
    always_comb begin
        case (op)
            OP_LD, OP_LDI, OP_ST, OP_BR, OP_ADDI: alu_op = ALU_ADD;
            OP_ANDI:                              alu_op = ALU_AND;
            OP_ORI:                               alu_op = ALU_OR;
            default:                              alu_op = ALU_NONE;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the Mini SRC datapath. Fetch runs
// T0-T2 for every instruction; execute runs T3-T7 keyed on IR[31:27].
module control_unit
    import cu_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        stop,
    output logic        run,
    output logic        PC_out,
    output logic        ZHigh_out,
    output logic        ZLow_out,
    output logic        MDR_out,
    output logic        HI_out,
    output logic        LO_out,
    output logic        C_out,
    output logic        In_port_out,
    output logic        MDR_enable,
    output logic        MAR_enable,
    output logic        Z_enable,
    output logic        Y_enable,
    output logic        PC_enable,
    output logic        IR_enable,
    output logic        Read,
    output logic        IncPC,
    output logic        RAM_write_enable,
    output logic        out_port_enable,
    output logic        in_port_in,
    output logic        con_in,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        R_in,
    output logic        R_out,
    output logic        BA_out,
    output logic [4:0]  opcode,
    output logic        illegal
);

    state_t          state_r;
    state_t          next_state_s;
    state_t          end_state_s;
    instr_class_t    cls_s;
    logic [OP_W-1:0] op_s;
    logic [OP_W-1:0] map_op_s;
    ctrl_t           ctrl_s;
    logic            unused_ir_s;

    assign op_s        = IR[31:27];
    assign cls_s       = decode_class(op_s);
    assign unused_ir_s = ^IR[26:0];

    alu_opcode_map u_alu_opcode_map (
        .op     (op_s),
        .alu_op (map_op_s)
    );

    // State register; clr low aborts whatever step is in progress.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r <= RESET_S;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Instruction-boundary target: pause only between instructions.
    always_comb begin
        if (stop) begin
            end_state_s = PAUSE;
        end else begin
            end_state_s = T0;
        end
    end

    // Step sequencing; each instruction class ends at its last execute step.
    always_comb begin
        next_state_s = T0;
        case (state_r)
            RESET_S: next_state_s = T0;
            T0:      next_state_s = T1;
            T1:      next_state_s = T2;
            T2: begin
                case (cls_s)
                    CLS_NOP:  next_state_s = end_state_s;
                    CLS_HALT: next_state_s = HALT;
                    default:  next_state_s = T3;
                endcase
            end
            T3: begin
                if (cls_s == CLS_ILL) begin
                    next_state_s = end_state_s;
                end else begin
                    next_state_s = T4;
                end
            end
            T4:      next_state_s = T5;
            T5: begin
                case (cls_s)
                    CLS_LDI, CLS_ALU, CLS_IMM: next_state_s = end_state_s;
                    default:                   next_state_s = T6;
                endcase
            end
            T6: begin
                if (cls_s == CLS_BR) begin
                    next_state_s = end_state_s;
                end else begin
                    next_state_s = T7;
                end
            end
            T7:      next_state_s = end_state_s;
            PAUSE: begin
                if (stop) begin
                    next_state_s = PAUSE;
                end else begin
                    next_state_s = T0;
                end
            end
            HALT:    next_state_s = HALT;
            default: next_state_s = T0;
        endcase
    end

    // Control word decoded from the current step and the instruction class.
    always_comb begin
        ctrl_s = '0;
        case (state_r)
            T0: begin
                ctrl_s.run        = 1'b1;
                ctrl_s.pc_out     = 1'b1;
                ctrl_s.mar_enable = 1'b1;
                ctrl_s.inc_pc     = 1'b1;
                ctrl_s.pc_enable  = 1'b1;
            end
            T1: begin
                ctrl_s.run        = 1'b1;
                ctrl_s.read       = 1'b1;
                ctrl_s.mdr_enable = 1'b1;
            end
            T2: begin
                ctrl_s.run       = 1'b1;
                ctrl_s.mdr_out   = 1'b1;
                ctrl_s.ir_enable = 1'b1;
            end
            T3: begin
                ctrl_s.run = 1'b1;
                case (cls_s)
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        ctrl_s.grb      = 1'b1;
                        ctrl_s.ba_out   = 1'b1;
                        ctrl_s.y_enable = 1'b1;
                    end
                    CLS_ALU, CLS_IMM: begin
                        ctrl_s.grb      = 1'b1;
                        ctrl_s.r_out    = 1'b1;
                        ctrl_s.y_enable = 1'b1;
                    end
                    CLS_BR: begin
                        ctrl_s.gra    = 1'b1;
                        ctrl_s.r_out  = 1'b1;
                        ctrl_s.con_in = 1'b1;
                    end
                    CLS_ILL: ctrl_s.illegal = 1'b1;
                    default: ;
                endcase
            end
            T4: begin
                ctrl_s.run = 1'b1;
                case (cls_s)
                    CLS_LD, CLS_LDI, CLS_ST, CLS_IMM: begin
                        ctrl_s.c_out    = 1'b1;
                        ctrl_s.z_enable = 1'b1;
                        ctrl_s.opcode   = map_op_s;
                    end
                    CLS_ALU: begin
                        ctrl_s.grc      = 1'b1;
                        ctrl_s.r_out    = 1'b1;
                        ctrl_s.z_enable = 1'b1;
                        ctrl_s.opcode   = op_s;
                    end
                    CLS_BR: begin
                        ctrl_s.pc_out   = 1'b1;
                        ctrl_s.y_enable = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                ctrl_s.run = 1'b1;
                case (cls_s)
                    CLS_LD, CLS_ST: begin
                        ctrl_s.zlow_out   = 1'b1;
                        ctrl_s.mar_enable = 1'b1;
                    end
                    CLS_LDI, CLS_ALU, CLS_IMM: begin
                        ctrl_s.zlow_out = 1'b1;
                        ctrl_s.gra      = 1'b1;
                        ctrl_s.r_in     = 1'b1;
                    end
                    CLS_BR: begin
                        ctrl_s.c_out    = 1'b1;
                        ctrl_s.z_enable = 1'b1;
                        ctrl_s.opcode   = map_op_s;
                    end
                    default: ;
                endcase
            end
            T6: begin
                ctrl_s.run = 1'b1;
                case (cls_s)
                    CLS_LD: begin
                        ctrl_s.read       = 1'b1;
                        ctrl_s.mdr_enable = 1'b1;
                    end
                    CLS_ST: begin
                        // MDR loads from the bus, not memory: Read stays low.
                        ctrl_s.gra        = 1'b1;
                        ctrl_s.r_out      = 1'b1;
                        ctrl_s.mdr_enable = 1'b1;
                    end
                    CLS_BR: begin
                        if (CON_FF) begin
                            ctrl_s.zlow_out  = 1'b1;
                            ctrl_s.pc_enable = 1'b1;
                        end else begin
                            ctrl_s.zlow_out  = 1'b0;
                            ctrl_s.pc_enable = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            T7: begin
                ctrl_s.run = 1'b1;
                case (cls_s)
                    CLS_LD: begin
                        ctrl_s.mdr_out = 1'b1;
                        ctrl_s.gra     = 1'b1;
                        ctrl_s.r_in    = 1'b1;
                    end
                    CLS_ST:  ctrl_s.ram_write_enable = 1'b1;
                    default: ;
                endcase
            end
            RESET_S, PAUSE, HALT: ctrl_s = '0;
            default:              ctrl_s = '0;
        endcase
    end

    assign run              = ctrl_s.run;
    assign illegal          = ctrl_s.illegal;
    assign opcode           = ctrl_s.opcode;
    assign PC_out           = ctrl_s.pc_out;
    assign ZHigh_out        = ctrl_s.zhigh_out;
    assign ZLow_out         = ctrl_s.zlow_out;
    assign MDR_out          = ctrl_s.mdr_out;
    assign HI_out           = ctrl_s.hi_out;
    assign LO_out           = ctrl_s.lo_out;
    assign C_out            = ctrl_s.c_out;
    assign In_port_out      = ctrl_s.in_port_out;
    assign MDR_enable       = ctrl_s.mdr_enable;
    assign MAR_enable       = ctrl_s.mar_enable;
    assign Z_enable         = ctrl_s.z_enable;
    assign Y_enable         = ctrl_s.y_enable;
    assign PC_enable        = ctrl_s.pc_enable;
    assign IR_enable        = ctrl_s.ir_enable;
    assign Read             = ctrl_s.read;
    assign IncPC            = ctrl_s.inc_pc;
    assign RAM_write_enable = ctrl_s.ram_write_enable;
    assign out_port_enable  = ctrl_s.out_port_enable;
    assign in_port_in       = ctrl_s.in_port_in;
    assign con_in           = ctrl_s.con_in;
    assign Gra              = ctrl_s.gra;
    assign Grb              = ctrl_s.grb;
    assign Grc              = ctrl_s.grc;
    assign R_in             = ctrl_s.r_in;
    assign R_out            = ctrl_s.r_out;
    assign BA_out           = ctrl_s.ba_out;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed table of instructions,
// hand-written reset/stop/halt sequences, and randomized instructions
// checked against a step-list reference model.
module tb_control_unit;

    typedef logic [32:0] word_t;

    localparam word_t PCO   = 33'h1 << 0;
    localparam word_t ZHO   = 33'h1 << 1;
    localparam word_t ZLO   = 33'h1 << 2;
    localparam word_t MDRO  = 33'h1 << 3;
    localparam word_t HIO   = 33'h1 << 4;
    localparam word_t LOO   = 33'h1 << 5;
    localparam word_t COUT  = 33'h1 << 6;
    localparam word_t INPO  = 33'h1 << 7;
    localparam word_t MDRE  = 33'h1 << 8;
    localparam word_t MARE  = 33'h1 << 9;
    localparam word_t ZEN   = 33'h1 << 10;
    localparam word_t YEN   = 33'h1 << 11;
    localparam word_t PCE   = 33'h1 << 12;
    localparam word_t IRE   = 33'h1 << 13;
    localparam word_t READ  = 33'h1 << 14;
    localparam word_t INCPC = 33'h1 << 15;
    localparam word_t RAMW  = 33'h1 << 16;
    localparam word_t OUTPE = 33'h1 << 17;
    localparam word_t INPI  = 33'h1 << 18;
    localparam word_t CONIN = 33'h1 << 19;
    localparam word_t GRA   = 33'h1 << 20;
    localparam word_t GRB   = 33'h1 << 21;
    localparam word_t GRC   = 33'h1 << 22;
    localparam word_t RIN   = 33'h1 << 23;
    localparam word_t ROUT  = 33'h1 << 24;
    localparam word_t BAO   = 33'h1 << 25;
    localparam word_t ILL   = 33'h1 << 26;
    localparam word_t RUN   = 33'h1 << 27;

    localparam word_t T0W = RUN | PCO | MARE | INCPC | PCE;
    localparam word_t T1W = RUN | READ | MDRE;
    localparam word_t T2W = RUN | MDRO | IRE;

    logic        clk;
    logic        clr;
    logic [31:0] IR;
    logic        CON_FF;
    logic        stop;
    logic        run, PC_out, ZHigh_out, ZLow_out, MDR_out, HI_out, LO_out, C_out;
    logic        In_port_out, MDR_enable, MAR_enable, Z_enable, Y_enable, PC_enable;
    logic        IR_enable, Read, IncPC, RAM_write_enable, out_port_enable, in_port_in;
    logic        con_in, Gra, Grb, Grc, R_in, R_out, BA_out, illegal;
    logic [4:0]  opcode;

    int          n_checks;
    int          n_err;
    logic [31:0] cur_ir;
    logic        cur_con;
    word_t       exp_q[$];

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic        con;
        int          len;
        word_t       exp[8];
    } vec_t;

    vec_t tbl[$];

    control_unit dut (
        .clk(clk), .clr(clr), .IR(IR), .CON_FF(CON_FF), .stop(stop),
        .run(run), .PC_out(PC_out), .ZHigh_out(ZHigh_out), .ZLow_out(ZLow_out),
        .MDR_out(MDR_out), .HI_out(HI_out), .LO_out(LO_out), .C_out(C_out),
        .In_port_out(In_port_out), .MDR_enable(MDR_enable), .MAR_enable(MAR_enable),
        .Z_enable(Z_enable), .Y_enable(Y_enable), .PC_enable(PC_enable),
        .IR_enable(IR_enable), .Read(Read), .IncPC(IncPC),
        .RAM_write_enable(RAM_write_enable), .out_port_enable(out_port_enable),
        .in_port_in(in_port_in), .con_in(con_in), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .R_in(R_in), .R_out(R_out), .BA_out(BA_out), .opcode(opcode), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic word_t opw(input logic [4:0] o);
        return word_t'(o) << 28;
    endfunction

    function automatic word_t pack_dut();
        word_t w;
        w = '0;
        w[0] = PC_out;       w[1] = ZHigh_out;   w[2] = ZLow_out;    w[3] = MDR_out;
        w[4] = HI_out;       w[5] = LO_out;      w[6] = C_out;       w[7] = In_port_out;
        w[8] = MDR_enable;   w[9] = MAR_enable;  w[10] = Z_enable;   w[11] = Y_enable;
        w[12] = PC_enable;   w[13] = IR_enable;  w[14] = Read;       w[15] = IncPC;
        w[16] = RAM_write_enable; w[17] = out_port_enable; w[18] = in_port_in;
        w[19] = con_in;      w[20] = Gra;        w[21] = Grb;        w[22] = Grc;
        w[23] = R_in;        w[24] = R_out;      w[25] = BA_out;     w[26] = illegal;
        w[27] = run;         w[32:28] = opcode;
        return w;
    endfunction

    task automatic check(input string nm, input word_t exp);
        word_t act;
        act = pack_dut();
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock step: drive inputs at the falling edge, then compare.
    task automatic step(input string nm, input word_t exp, input logic stop_v);
        @(negedge clk);
        IR     = cur_ir;
        CON_FF = cur_con;
        stop   = stop_v;
        #1;
        check(nm, exp);
    endtask

    // Reference model: list of control words, one per clock, for an instruction.
    task automatic build_model(input logic [31:0] ir, input logic con);
        logic [4:0] op;
        word_t      imm_alu[3];
        imm_alu = '{opw(5'd3), opw(5'd5), opw(5'd6)};
        op = ir[31:27];
        exp_q = {T0W, T1W, T2W};
        if (op == 5'd26) begin
        end else if (op <= 5'd2) begin
            exp_q.push_back(RUN | GRB | BAO | YEN);
            exp_q.push_back(RUN | COUT | ZEN | opw(5'd3));
            if (op == 5'd1) begin
                exp_q.push_back(RUN | ZLO | GRA | RIN);
            end else begin
                exp_q.push_back(RUN | ZLO | MARE);
                if (op == 5'd0) begin
                    exp_q.push_back(RUN | READ | MDRE);
                    exp_q.push_back(RUN | MDRO | GRA | RIN);
                end else begin
                    exp_q.push_back(RUN | GRA | ROUT | MDRE);
                    exp_q.push_back(RUN | RAMW);
                end
            end
        end else if (op <= 5'd11) begin
            exp_q.push_back(RUN | GRB | ROUT | YEN);
            exp_q.push_back(RUN | GRC | ROUT | ZEN | opw(op));
            exp_q.push_back(RUN | ZLO | GRA | RIN);
        end else if (op <= 5'd14) begin
            exp_q.push_back(RUN | GRB | ROUT | YEN);
            exp_q.push_back(RUN | COUT | ZEN | imm_alu[op - 5'd12]);
            exp_q.push_back(RUN | ZLO | GRA | RIN);
        end else if (op == 5'd19) begin
            exp_q.push_back(RUN | GRA | ROUT | CONIN);
            exp_q.push_back(RUN | PCO | YEN);
            exp_q.push_back(RUN | COUT | ZEN | opw(5'd3));
            exp_q.push_back(con ? (RUN | ZLO | PCE) : RUN);
        end else begin
            exp_q.push_back(RUN | ILL);
        end
    endtask

    task automatic run_instr(input string nm, input logic [31:0] ir, input logic con,
                             input logic stop_end, input int pause_n);
        build_model(ir, con);
        cur_ir  = ir;
        cur_con = con;
        for (int i = 0; i < exp_q.size(); i++) begin
            step($sformatf("%s_T%0d", nm, i), exp_q[i],
                 (i == exp_q.size() - 1) ? stop_end : 1'($urandom_range(0, 1)));
        end
        if (stop_end) begin
            for (int p = 0; p < pause_n; p++) begin
                step($sformatf("%s_pause%0d", nm, p), '0, p < pause_n - 1);
            end
        end
    endtask

    task automatic add_vec(input string nm, input logic [31:0] ir, input logic con,
                           input int len, input word_t w3, input word_t w4,
                           input word_t w5, input word_t w6, input word_t w7);
        vec_t v;
        word_t w[8];
        w = '{T0W, T1W, T2W, w3, w4, w5, w6, w7};
        v.name = nm;
        v.ir   = ir;
        v.con  = con;
        v.len  = len;
        for (int i = 0; i < 8; i++) begin
            v.exp[i] = (i < 3) ? w[i] : ((i < len) ? (RUN | w[i]) : '0);
        end
        tbl.push_back(v);
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        cur_ir   = 32'h1A920000;
        cur_con  = 1'b0;
        IR       = cur_ir;
        CON_FF   = 1'b0;
        stop     = 1'b0;
        clr      = 1'b1;
        #1 clr   = 1'b0;

        // Directed vectors: inputs and the full expected step sequence.
        add_vec("add", 32'h1A920000, 1'b0, 6, GRB | ROUT | YEN,
                GRC | ROUT | ZEN | opw(5'd3), ZLO | GRA | RIN, '0, '0);
        add_vec("ld", 32'h01000095, 1'b0, 8, GRB | BAO | YEN,
                COUT | ZEN | opw(5'd3), ZLO | MARE, READ | MDRE, MDRO | GRA | RIN);
        add_vec("st", 32'h10880087, 1'b0, 8, GRB | BAO | YEN,
                COUT | ZEN | opw(5'd3), ZLO | MARE, GRA | ROUT | MDRE, RAMW);
        add_vec("ldi", 32'h08800005, 1'b0, 6, GRB | BAO | YEN,
                COUT | ZEN | opw(5'd3), ZLO | GRA | RIN, '0, '0);
        add_vec("addi", 32'h61A7FFFB, 1'b0, 6, GRB | ROUT | YEN,
                COUT | ZEN | opw(5'd3), ZLO | GRA | RIN, '0, '0);
        add_vec("andi", 32'h68000000, 1'b0, 6, GRB | ROUT | YEN,
                COUT | ZEN | opw(5'd5), ZLO | GRA | RIN, '0, '0);
        add_vec("ori", 32'h70000000, 1'b0, 6, GRB | ROUT | YEN,
                COUT | ZEN | opw(5'd6), ZLO | GRA | RIN, '0, '0);
        add_vec("sub", 32'h20000000, 1'b0, 6, GRB | ROUT | YEN,
                GRC | ROUT | ZEN | opw(5'd4), ZLO | GRA | RIN, '0, '0);
        add_vec("rol", 32'h58000000, 1'b0, 6, GRB | ROUT | YEN,
                GRC | ROUT | ZEN | opw(5'd11), ZLO | GRA | RIN, '0, '0);
        add_vec("br1", 32'h9A80000E, 1'b1, 7, GRA | ROUT | CONIN, PCO | YEN,
                COUT | ZEN | opw(5'd3), ZLO | PCE, '0);
        add_vec("br0", 32'h9A80000E, 1'b0, 7, GRA | ROUT | CONIN, PCO | YEN,
                COUT | ZEN | opw(5'd3), '0, '0);
        add_vec("nop", 32'hD0000000, 1'b0, 3, '0, '0, '0, '0, '0);
        add_vec("mul", 32'h78000000, 1'b0, 4, ILL, '0, '0, '0, '0);
        add_vec("jr", 32'hA0000000, 1'b0, 4, ILL, '0, '0, '0, '0);
        add_vec("op31", 32'hF8000000, 1'b0, 4, ILL, '0, '0, '0, '0);

        // Reset held for three cycles, then release enters T0.
        for (int i = 0; i < 3; i++) step("reset", '0, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        #1 check("reset_release", '0);

        for (int k = 0; k < tbl.size(); k++) begin
            cur_ir  = tbl[k].ir;
            cur_con = tbl[k].con;
            for (int s = 0; s < tbl[k].len; s++) begin
                step($sformatf("%s_T%0d", tbl[k].name, s), tbl[k].exp[s], 1'b0);
            end
        end

        // stop raised in add T4: PAUSE after T5, T0 once stop drops.
        cur_ir = 32'h1A920000;
        step("stop_T0", T0W, 1'b0);
        step("stop_T1", T1W, 1'b0);
        step("stop_T2", T2W, 1'b0);
        step("stop_T3", RUN | GRB | ROUT | YEN, 1'b0);
        step("stop_T4", RUN | GRC | ROUT | ZEN | opw(5'd3), 1'b1);
        step("stop_T5", RUN | ZLO | GRA | RIN, 1'b1);
        step("stop_pause0", '0, 1'b1);
        step("stop_pause1", '0, 1'b0);
        step("stop_resume", T0W, 1'b0);
        step("stop_resume_T1", T1W, 1'b0);
        step("stop_resume_T2", T2W, 1'b0);
        step("stop_resume_T3", RUN | GRB | ROUT | YEN, 1'b0);
        step("stop_resume_T4", RUN | GRC | ROUT | ZEN | opw(5'd3), 1'b0);
        step("stop_resume_T5", RUN | ZLO | GRA | RIN, 1'b0);

        // Reset in the middle of ld aborts it.
        cur_ir = 32'h01000095;
        step("mid_T0", T0W, 1'b0);
        step("mid_T1", T1W, 1'b0);
        step("mid_T2", T2W, 1'b0);
        step("mid_T3", RUN | GRB | BAO | YEN, 1'b0);
        step("mid_T4", RUN | COUT | ZEN | opw(5'd3), 1'b0);
        #2 clr = 1'b0;
        #1 check("mid_reset", '0);
        @(negedge clk);
        clr = 1'b1;
        #1 check("mid_reset_release", '0);
        run_instr("after_mid", 32'h01000095, 1'b0, 1'b0, 1);

        // Randomized instructions against the reference model.
        for (int n = 0; n < 60; n++) begin
            logic [4:0]  op;
            logic [31:0] r;
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd26;
            r = $urandom();
            run_instr($sformatf("rnd%0d_op%0d", n, op), {op, r[26:0]},
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                      int'($urandom_range(1, 3)));
        end

        // halt with stop high: HALT wins and holds until clr.
        cur_ir = 32'hD8000000;
        step("halt_T0", T0W, 1'b0);
        step("halt_T1", T1W, 1'b0);
        step("halt_T2", T2W, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step($sformatf("halt_hold%0d", i), '0, 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        clr  = 1'b0;
        stop = 1'b0;
        #1 check("halt_clr", '0);
        @(negedge clk);
        clr = 1'b1;
        #1 check("halt_clr_release", '0);
        run_instr("after_halt", 32'h1A920000, 1'b0, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Moore control sequencer that drives every control input of Datapath. Replaces hand-driven testbench stimulus.
- Fetch T0–T2 is shared by all instructions. Execute runs T3–T7 and depends on IR[31:27].
- Supports ld, ldi, st, R-type ALU ops (add..rol), addi/andi/ori, br, nop and halt. Handles stop/pause and reports run status.

Parameters:
- NUM_STEPS, 8, number of control steps T0..T7 (state counter sizing).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-low.
- IR  in  32  instruction register contents from Datapath.
- CON_FF  in  1  branch condition flip-flop from Datapath.
- stop  in  1  pause request, sampled at instruction boundary.
- run  out  1  high while fetching or executing; low in PAUSE, HALT and RESET_S.
- PC_out, ZHigh_out, ZLow_out, MDR_out, HI_out, LO_out, C_out, In_port_out  out  1 each  bus source selects.
- MDR_enable, MAR_enable, Z_enable, Y_enable, PC_enable, IR_enable  out  1 each  register loads.
- Read, IncPC, RAM_write_enable, out_port_enable, in_port_in, con_in  out  1 each.
- Gra, Grb, Grc, R_in, R_out, BA_out  out  1 each  select-and-encode controls.
- opcode  out  5  ALU operation.
- illegal  out  1  one-cycle pulse at T3 on an unsupported opcode.

Behaviour:
- Reset: clr low asynchronously forces state RESET_S. All outputs are 0 in RESET_S, opcode is 5'b00000 and run is 0. The first clk edge after clr rises moves to T0. Reset mid-instruction aborts it with no partial writes after the clr edge.
- Outputs decode state and IR only (Moore). Each step lasts exactly one clock. Any signal not listed for a step is 0.
- T0: PC_out, MAR_enable, IncPC, PC_enable.
- T1: Read, MDR_enable.
- T2: MDR_out, IR_enable.
- Dispatch after T2 on IR[31:27]:
  - nop (11010) goes to T0.
  - halt (11011) goes to HALT.
  - Unsupported opcodes pulse illegal in T3, then go to T0.
- ld (00000): T3 Grb, BA_out, Y_enable; T4 C_out, opcode=00011, Z_enable; T5 ZLow_out, MAR_enable; T6 Read, MDR_enable; T7 MDR_out, Gra, R_in.
- ldi (00001): T3–T4 as ld; T5 ZLow_out, Gra, R_in.
- st (00010): T3–T5 as ld; T6 Gra, R_out, MDR_enable with Read=0; T7 RAM_write_enable.
- R-type (00011..01011): T3 Grb, R_out, Y_enable; T4 Grc, R_out, Z_enable, opcode=IR[31:27]; T5 ZLow_out, Gra, R_in.
- Immediates: T3 Grb, R_out, Y_enable; T4 C_out, Z_enable, opcode mapped (addi 01100 to 00011, andi 01101 to 00101, ori 01110 to 00110); T5 ZLow_out, Gra, R_in.
- br (10011): T3 Gra, R_out, con_in; T4 PC_out, Y_enable; T5 C_out, opcode=00011, Z_enable.
  - T6 samples CON_FF. If 1: ZLow_out, PC_enable. If 0: all outputs 0.
- The last execute step goes to T0, or to PAUSE if stop=1 at that edge.
- PAUSE: all outputs 0. Moves to T0 on the first edge with stop=0. stop has no effect mid-instruction.
- HALT: all outputs 0, run=0, absorbing. Only clr exits.
- Simultaneous halt opcode and stop: HALT wins.
- Step counter never wraps past T7. Unreachable state encodings go to T0.

Decomposition:
- Package cu_pkg: opcode localparams (all 28 Mini SRC opcodes), state encoding (RESET_S, T0..T7, PAUSE, HALT), ALU opcode constants.
- One sub-module, alu_opcode_map: combinational IR[31:27] to ALU opcode for the immediate and address-add cases.

Test Plan:
- Reset: hold clr=0 for 3 cycles with IR=0x1A920000 -> all outputs 0 and run=0; first edge after release enters T0 with PC_out=MAR_enable=IncPC=PC_enable=1.
- ld R2,0x95 (IR=0x01000095): check the exact T3–T7 signal set; Z_enable coincides with opcode=00011 in T4; Gra=R_in=1 only in T7; back to T0 after 8 cycles.
- add R5,R2,R4 (IR=0x1A920000): T4 opcode=00011 with Grc=R_out=Z_enable=1; T5 ZLow_out=Gra=R_in=1; 6-cycle instruction.
- st 0x87(R1),R1 (IR=0x10880087): T6 MDR_enable=1 and Read=0; RAM_write_enable=1 only in T7.
- addi R3,R4,-5 (IR=0x61A7FFFB): T4 opcode=00011 with C_out=1. brzr R5,14 (IR=0x9A80000E): CON_FF=1 gives PC_enable=1 in T6; CON_FF=0 gives PC_enable=0 in T6.
- stop=1 during add T4 -> PAUSE after T5 with run=0; release stop -> T0 next edge. halt (IR=0xD8000000) -> HALT, outputs stay 0 for 20 cycles until clr pulse.
